// File: rtl/match_event_monitor.sv
// -----------------------------------------------------------------------------
// match_event_monitor
//
// Consumes the match output (y) of a serial pattern detector. It counts match
// events over the lifetime of the block and within fixed windows of WIN_LEN
// cycles. When a window ends with THRESH or more matches, a sticky alarm is
// raised and held until software acknowledges it.
//
// Parameters
//   CNT_W    width of total_count / win_count (both saturate at all-ones)
//   WIN_LEN  window length in clk cycles (>= 2)
//   THRESH   matches per window that raise the alarm (1 .. 2^CNT_W-1)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   det_in       in   match indication from the detector, synchronous to clk
//   enable       in   1 = monitor runs, 0 = idle (forces IDLE, clears alarm)
//   clr          in   synchronous clear of total_count (wins over an event)
//   alarm_ack    in   one-cycle acknowledge; releases the alarm in HOLD only
//   event_p      out  registered one-cycle pulse per counted event
//   total_count  out  lifetime event count, saturating
//   win_count    out  events in the current window, saturating
//   alarm        out  sticky threshold alarm
//
// Build option
//   MON_EDGE_DETECT_EN  when defined, only rising edges of det_in are events,
//                       so a level held for N cycles counts once. When
//                       undefined, every cycle with det_in=1 is an event.
// -----------------------------------------------------------------------------
module match_event_monitor #(
  parameter int CNT_W   = 10,
  parameter int WIN_LEN = 64,
  parameter int THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_in,
  input  logic             enable,
  input  logic             clr,
  input  logic             alarm_ack,
  output logic             event_p,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] win_count,
  output logic             alarm
);

  localparam int               TMR_W     = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [CNT_W-1:0]   r_win;
  logic [CNT_W-1:0]   w_win_nxt;
  logic [CNT_W-1:0]   w_win_inc;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   w_total_nxt;
  logic               r_event_p;
  logic               r_alarm;
  logic               w_ev;
  logic               w_active;

  // ---------------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------------
`ifdef MON_EDGE_DETECT_EN
  // History of det_in, updated in every state so that a level already high
  // when the monitor is enabled does not look like a fresh edge.
  logic r_det_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_det_q <= 1'b0;
    end else begin
      r_det_q <= det_in;
    end
  end

  assign w_ev = det_in & ~r_det_q;
`else
  assign w_ev = det_in;
`endif

  assign w_active = (r_state != S_IDLE);

  // Window count including this cycle's event, saturating at all-ones. At the
  // window boundary this is the value compared against THRESH, so an event on
  // the final cycle of the window still counts.
  assign w_win_inc = (r_win == CNT_MAX) ? r_win
                                         : r_win + {{(CNT_W-1){1'b0}}, w_ev};

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_win_nxt   = r_win;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_win_nxt   = '0;
        if (enable) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (r_timer == TMR_LAST) begin
          w_timer_nxt = '0;
          if (w_win_inc >= THRESH_C) begin
            w_state_nxt = S_HOLD;
            w_win_nxt   = w_win_inc;
          end else begin
            w_win_nxt   = '0;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          w_win_nxt   = w_win_inc;
        end
      end

      S_HOLD: begin
        // Timer and window count stay frozen until acknowledged.
        if (alarm_ack) begin
          w_state_nxt = S_RUN;
          w_timer_nxt = '0;
          w_win_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_win_nxt   = '0;
      end
    endcase

    // Dropping enable returns to IDLE from any state and overrides alarm_ack.
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
      w_win_nxt   = '0;
    end
  end

  always_comb begin
    w_total_nxt = r_total;
    if (clr) begin
      w_total_nxt = '0;
    end else if (w_active && w_ev && (r_total != CNT_MAX)) begin
      w_total_nxt = r_total + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_win     <= '0;
      r_total   <= '0;
      r_event_p <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_win     <= w_win_nxt;
      r_total   <= w_total_nxt;
      r_event_p <= w_ev & w_active;
      r_alarm   <= (w_state_nxt == S_HOLD);
    end
  end

  assign event_p     = r_event_p;
  assign total_count = r_total;
  assign win_count   = r_win;
  assign alarm       = r_alarm;

endmodule

// File: tb/tb_match_event_monitor.sv
// -----------------------------------------------------------------------------
// tb_match_event_monitor
//
// Self-checking bench for match_event_monitor. A short table of per-cycle
// vectors covers IDLE/RUN entry, counting and clr; hand-written sequences cover
// window evaluation, HOLD/ack, enable override, async reset, saturation (on a
// second instance with CNT_W=3) and held-level behaviour under either build of
// MON_EDGE_DETECT_EN. Inputs change 1 ns after a rising edge, outputs are
// checked at that same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_match_event_monitor;

  localparam int CNT_W   = 10;
  localparam int SAT_W   = 3;
  localparam int WIN_LEN = 64;
  localparam int THRESH  = 4;

  logic             clk;
  logic             rst_n;
  logic             det_in;
  logic             enable;
  logic             clr;
  logic             alarm_ack;
  logic             event_p;
  logic [CNT_W-1:0] total_count;
  logic [CNT_W-1:0] win_count;
  logic             alarm;
  logic             s_event_p;
  logic [SAT_W-1:0] s_total_count;
  logic [SAT_W-1:0] s_win_count;
  logic             s_alarm;

  int n_tests = 0;
  int n_fail  = 0;

  match_event_monitor #(
    .CNT_W   (CNT_W),
    .WIN_LEN (WIN_LEN),
    .THRESH  (THRESH)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .det_in      (det_in),
    .enable      (enable),
    .clr         (clr),
    .alarm_ack   (alarm_ack),
    .event_p     (event_p),
    .total_count (total_count),
    .win_count   (win_count),
    .alarm       (alarm)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  match_event_monitor #(
    .CNT_W   (SAT_W),
    .WIN_LEN (WIN_LEN),
    .THRESH  (THRESH)
  ) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .det_in      (det_in),
    .enable      (enable),
    .clr         (clr),
    .alarm_ack   (alarm_ack),
    .event_p     (s_event_p),
    .total_count (s_total_count),
    .win_count   (s_win_count),
    .alarm       (s_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic det;
    logic en;
    logic clr;
    logic ack;
    logic exp_ev;
    int   exp_total;
    int   exp_win;
    logic exp_alarm;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic d, input logic e, input logic c, input logic a);
    det_in    = d;
    enable    = e;
    clr       = c;
    alarm_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    det_in = 1'b0; enable = 1'b0; clr = 1'b0; alarm_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs one RUN window (timer 0..WIN_LEN-1) with pulses at the given offsets.
  task automatic run_window(input int p0, input int p1, input int p2, input int p3,
                            input int ack_at);
    for (int t = 0; t < WIN_LEN; t++) begin
      tick((t == p0) || (t == p1) || (t == p2) || (t == p3), 1'b1, 1'b0, t == ack_at);
      if (t == ack_at) begin
        check("run_ack_ignored.alarm", alarm, 0);
        check("run_ack_ignored.win", win_count, 4);
      end
      if (t == WIN_LEN - 2) begin
        check("pre_eval.alarm", alarm, 0);
      end
    end
  endtask

  initial begin
    int ev_pulses;
    int exp_hold;

    // Isolated pulses only, so the table holds for either event mode.
    //           det  en   clr  ack  ev   total win alarm
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 0, 0, 1'b0};  // IDLE ignores det_in
    vecs[1] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 0, 1'b0};  // IDLE -> RUN
    vecs[2] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1, 1, 1'b0};  // first event
    vecs[3] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1, 1, 1'b0};
    vecs[4] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 2, 2, 1'b0};
    vecs[5] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 0, 2, 1'b0};  // clr leaves window alone
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 0, 0, 1'b0};  // enable low -> IDLE
    vecs[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 0, 0, 1'b0};
    vecs[8] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 0, 0, 1'b0};  // ack outside HOLD

    rst_n = 1'b0;
    det_in = 1'b0; enable = 1'b0; clr = 1'b0; alarm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.event_p", event_p, 0);
    check("reset.total", total_count, 0);
    check("reset.win", win_count, 0);
    check("reset.alarm", alarm, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].det, vecs[i].en, vecs[i].clr, vecs[i].ack);
      check($sformatf("vec%0d.event_p", i), event_p, vecs[i].exp_ev);
      check($sformatf("vec%0d.total", i), total_count, vecs[i].exp_total);
      check($sformatf("vec%0d.win", i), win_count, vecs[i].exp_win);
      check($sformatf("vec%0d.alarm", i), alarm, vecs[i].exp_alarm);
    end

    // Test 1: three pulses in a window stay below threshold.
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < WIN_LEN; t++) begin
      tick((t == 5) || (t == 10) || (t == 20), 1'b1, 1'b0, 1'b0);
      if (t == 20) begin
        check("t1.total", total_count, 3);
        check("t1.win", win_count, 3);
      end
    end
    check("t1.win_after_window", win_count, 0);
    check("t1.alarm", alarm, 0);
    check("t1.total_after_window", total_count, 3);

    // Test 2: fourth pulse on the last cycle of the window trips the alarm.
    run_window(1, 3, 5, WIN_LEN - 1, -1);
    check("t2.alarm", alarm, 1);
    check("t2.win", win_count, 4);
    check("t2.total", total_count, 7);
    check("t2.event_p_last", event_p, 1);

    // Test 3: HOLD keeps counting total but freezes the window count.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("t3.hold_total", total_count, 9);
    check("t3.hold_win", win_count, 4);
    check("t3.hold_alarm", alarm, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    check("t3.ack_alarm", alarm, 0);
    check("t3.ack_win", win_count, 0);

    // Next window: ack while running is ignored; no alarm until evaluation.
    run_window(0, 2, 4, 6, 10);
    check("t3.alarm2", alarm, 1);
    check("t3.total2", total_count, 13);
    tick(1'b0, 1'b0, 1'b0, 1'b1);   // ack together with enable low
    check("t3.dis_alarm", alarm, 0);
    check("t3.dis_win", win_count, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3.idle_total", total_count, 13);
    check("t3.idle_event_p", event_p, 0);

    // Test 6: async reset in HOLD clears outputs without a clock edge.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_window(0, 2, 4, 6, -1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6.pre_alarm", alarm, 1);
    check("t6.pre_event_p", event_p, 1);
    check("t6.pre_total", total_count, 18);
    rst_n = 1'b0;
    enable = 1'b0;
    #2;
    check("t6.async_alarm", alarm, 0);
    check("t6.async_total", total_count, 0);
    check("t6.async_win", win_count, 0);
    check("t6.async_event_p", event_p, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6.no_count_disabled", total_count, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6.count_after_enable", total_count, 1);

    // Test 4: saturation on the 3-bit instance, then clr against an event.
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("t4.clr_total", total_count, 0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("t4.sat_total", s_total_count, 7);
    check("t4.sat_win", s_win_count, 7);
    check("t4.wide_total", total_count, 9);
    check("t4.wide_win", win_count, 10);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("t4.clr_wins_sat", s_total_count, 0);
    check("t4.clr_wins_wide", total_count, 0);

    // Test 5: det_in held high for five cycles.
`ifdef MON_EDGE_DETECT_EN
    exp_hold = 1;
`else
    exp_hold = 5;
`endif
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    ev_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      ev_pulses += int'(event_p);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    ev_pulses += int'(event_p);
    check("t5.held_total", total_count, exp_hold);
    check("t5.held_pulses", ev_pulses, exp_hold);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
